// File: rtl/hub75_receiver_if.sv
// Bundle of the HUB75 panel pins entering the receiver and the pixel/line
// event stream it produces. The master drives the pins; the receiver is the slave.
interface hub75_receiver_if #(
  parameter int COLBITS   = 6,
  parameter int ADDRBITS  = 5,
  parameter int PLANEBITS = 3,
  parameter int ONBITS    = 16
);
  logic                 led_sclk;
  logic                 led_latch;
  logic                 led_blank;
  logic [ADDRBITS-1:0]  led_addr;
  logic [2:0]           led_rgb1;
  logic [2:0]           led_rgb2;
  logic                 clr_err;

  logic                 pix_valid;
  logic [COLBITS-1:0]   pix_col;
  logic [2:0]           pix_rgb1;
  logic [2:0]           pix_rgb2;
  logic                 line_valid;
  logic [ADDRBITS-1:0]  line_row;
  logic [PLANEBITS-1:0] line_plane;
  logic [COLBITS:0]     line_cols;
  logic [ONBITS-1:0]    line_on_time;
  logic                 frame_start;
  logic                 err_overrun;

  modport master (
    output led_sclk, led_latch, led_blank, led_addr, led_rgb1, led_rgb2, clr_err,
    input  pix_valid, pix_col, pix_rgb1, pix_rgb2, line_valid, line_row,
           line_plane, line_cols, line_on_time, frame_start, err_overrun
  );

  modport slave (
    input  led_sclk, led_latch, led_blank, led_addr, led_rgb1, led_rgb2, clr_err,
    output pix_valid, pix_col, pix_rgb1, pix_rgb2, line_valid, line_row,
           line_plane, line_cols, line_on_time, frame_start, err_overrun
  );
endinterface

// File: rtl/hub75_receiver.sv
// HUB75 receiver: synchronizes panel pins into clk, emits one event per captured
// column and one per latch with row, bit-plane, column count and display on-time.
module hub75_receiver #(
  parameter int COLS      = 64,
  parameter int COLBITS   = 6,
  parameter int ADDRBITS  = 5,
  parameter int PLANEBITS = 3,
  parameter int ONBITS    = 16
) (
  input  logic           clk,
  input  logic           reset,
  hub75_receiver_if.slave bus
);

  localparam int               SW      = 3 + ADDRBITS + 6;
  localparam logic [COLBITS:0] COL_LIM = (COLBITS + 1)'(COLS);

  function automatic logic [ONBITS-1:0] sat_inc_on(input logic [ONBITS-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [PLANEBITS-1:0] sat_inc_plane(input logic [PLANEBITS-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [SW-1:0] pins;
  logic [SW-1:0] syn_p0_q, syn_p1_q;
  logic [1:0]    hist_p2_q;

  assign pins = {bus.led_sclk, bus.led_latch, bus.led_blank, bus.led_addr,
                 bus.led_rgb1, bus.led_rgb2};

  // p0/p1: two-flop synchronizer for every pin; p2: strobe history for edges
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      syn_p0_q  <= '0;
      syn_p1_q  <= '0;
      hist_p2_q <= '0;
    end else begin
      syn_p0_q  <= pins;
      syn_p1_q  <= syn_p0_q;
      hist_p2_q <= syn_p1_q[SW-1 -: 2];
    end
  end

  logic                sclk_rise, latch_rise, blank_s;
  logic [ADDRBITS-1:0] addr_s;
  logic [2:0]          rgb1_s, rgb2_s;

  assign sclk_rise  = syn_p1_q[SW-1] & ~hist_p2_q[1];
  assign latch_rise = syn_p1_q[SW-2] & ~hist_p2_q[0];
  assign blank_s    = syn_p1_q[SW-3];
  assign addr_s     = syn_p1_q[6 +: ADDRBITS];
  assign rgb1_s     = syn_p1_q[5:3];
  assign rgb2_s     = syn_p1_q[2:0];

  logic [COLBITS:0]     col_q, col_d;
  logic [ONBITS-1:0]    on_q, on_d;
  logic [ADDRBITS-1:0]  last_row_q, last_row_d;
  logic                 last_vld_q, last_vld_d;
  logic                 err_q, err_d;
  logic                 pix_valid_q, pix_valid_d;
  logic [COLBITS-1:0]   pix_col_q, pix_col_d;
  logic [2:0]           pix_rgb1_q, pix_rgb1_d, pix_rgb2_q, pix_rgb2_d;
  logic                 line_valid_q, line_valid_d;
  logic [ADDRBITS-1:0]  line_row_q, line_row_d;
  logic [PLANEBITS-1:0] line_plane_q, line_plane_d;
  logic [COLBITS:0]     line_cols_q, line_cols_d;
  logic [ONBITS-1:0]    line_on_q, line_on_d;
  logic                 frame_start_q, frame_start_d;

  logic                 col_cap, overrun;
  logic [COLBITS:0]     col_after;
  logic [PLANEBITS-1:0] plane_n;

  always_comb begin
    col_cap       = sclk_rise && (col_q < COL_LIM);
    overrun       = sclk_rise && !col_cap;
    col_after     = col_q + {{COLBITS{1'b0}}, col_cap};
    plane_n       = '0;

    col_d         = col_after;
    on_d          = blank_s ? on_q : sat_inc_on(on_q);
    last_row_d    = last_row_q;
    last_vld_d    = last_vld_q;
    err_d         = (err_q & ~bus.clr_err) | overrun;
    pix_valid_d   = col_cap;
    pix_col_d     = pix_col_q;
    pix_rgb1_d    = pix_rgb1_q;
    pix_rgb2_d    = pix_rgb2_q;
    line_valid_d  = 1'b0;
    line_row_d    = line_row_q;
    line_plane_d  = line_plane_q;
    line_cols_d   = line_cols_q;
    line_on_d     = line_on_q;
    frame_start_d = 1'b0;

    if (col_cap) begin
      pix_col_d  = col_q[COLBITS-1:0];
      pix_rgb1_d = rgb1_s;
      pix_rgb2_d = rgb2_s;
    end

    // A coincident pixel is already counted in col_after, so the line includes it
    if (latch_rise) begin
      if (last_vld_q && (addr_s == last_row_q))
        plane_n = sat_inc_plane(line_plane_q);
      line_valid_d  = 1'b1;
      line_row_d    = addr_s;
      line_plane_d  = plane_n;
      line_cols_d   = col_after;
      line_on_d     = on_q;
      col_d         = '0;
      on_d          = '0;
      last_row_d    = addr_s;
      last_vld_d    = 1'b1;
      frame_start_d = (addr_s == '0) && (plane_n == '0) &&
                      (!last_vld_q || (last_row_q != '0));
    end
  end

  // Output/event registers: one clk after edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_q         <= '0;
      on_q          <= '0;
      last_row_q    <= '0;
      last_vld_q    <= 1'b0;
      err_q         <= 1'b0;
      pix_valid_q   <= 1'b0;
      pix_col_q     <= '0;
      pix_rgb1_q    <= '0;
      pix_rgb2_q    <= '0;
      line_valid_q  <= 1'b0;
      line_row_q    <= '0;
      line_plane_q  <= '0;
      line_cols_q   <= '0;
      line_on_q     <= '0;
      frame_start_q <= 1'b0;
    end else begin
      col_q         <= col_d;
      on_q          <= on_d;
      last_row_q    <= last_row_d;
      last_vld_q    <= last_vld_d;
      err_q         <= err_d;
      pix_valid_q   <= pix_valid_d;
      pix_col_q     <= pix_col_d;
      pix_rgb1_q    <= pix_rgb1_d;
      pix_rgb2_q    <= pix_rgb2_d;
      line_valid_q  <= line_valid_d;
      line_row_q    <= line_row_d;
      line_plane_q  <= line_plane_d;
      line_cols_q   <= line_cols_d;
      line_on_q     <= line_on_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign bus.pix_valid    = pix_valid_q;
  assign bus.pix_col      = pix_col_q;
  assign bus.pix_rgb1     = pix_rgb1_q;
  assign bus.pix_rgb2     = pix_rgb2_q;
  assign bus.line_valid   = line_valid_q;
  assign bus.line_row     = line_row_q;
  assign bus.line_plane   = line_plane_q;
  assign bus.line_cols    = line_cols_q;
  assign bus.line_on_time = line_on_q;
  assign bus.frame_start  = frame_start_q;
  assign bus.err_overrun  = err_q;

endmodule
